// File: rtl/board_cursor_ctrl_if.sv
// Move-request handshake between the cursor controller (master) and game_logic (slave).
// The master holds valid/src/dst stable until it sees ready on a clock edge.
interface board_cursor_ctrl_if #(
  parameter int LOC_W = 6
);
  logic             move_valid;
  logic [LOC_W-1:0] move_src;
  logic [LOC_W-1:0] move_dst;
  logic             move_ready;

  modport master (output move_valid, move_src, move_dst, input move_ready);
  modport slave  (input move_valid, move_src, move_dst, output move_ready);
endinterface

// File: rtl/board_cursor_ctrl.sv
// Button conditioning, board cursor and two-press select FSM issuing move requests to game_logic.
// Optional feature macro: AUTO_REPEAT_EN (held direction buttons auto-repeat).
module board_cursor_ctrl #(
  parameter int BOARD_DIM       = 8,
  parameter int LOC_W           = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WRAP            = 0,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_btn_up,
  input  logic             in_btn_down,
  input  logic             in_btn_left,
  input  logic             in_btn_right,
  input  logic             in_selected,
  output logic [LOC_W-1:0] location,
  output logic [LOC_W-1:0] sel_loc,
  output logic             sel_valid,
  board_cursor_ctrl_if.master req
);

  localparam int NB   = 5;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LOC_W-1:0] LAST    = LOC_W'(BOARD_DIM - 1);
  localparam logic [LOC_W-1:0] DIM     = LOC_W'(BOARD_DIM);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PICKED   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 select.
  logic [NB-1:0]    raw_s, sync1_r, sync2_r, stable_s, stable_d_r, press_s;
  logic [3:0]       dir_s;
  logic             sel_press_s;
  logic [LOC_W-1:0] row_r, col_r, row_nxt_s, col_nxt_s;
  logic [LOC_W-1:0] location_r, sel_loc_r, move_src_r, move_dst_r;
  logic             sel_valid_r, move_valid_r;
  logic [1:0]       state_r;

  assign raw_s = {in_selected, in_btn_right, in_btn_left, in_btn_down, in_btn_up};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {NB{1'b0}};
      sync2_r <= {NB{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_db
    logic [DB_W-1:0] cnt_r;
    logic            level_r;
    // Debounce: the level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r   <= {DB_W{1'b0}};
        level_r <= 1'b0;
      end else if (sync2_r[g] == level_r) begin
        cnt_r <= {DB_W{1'b0}};
      end else if (cnt_r == DB_LAST) begin
        cnt_r   <= {DB_W{1'b0}};
        level_r <= sync2_r[g];
      end else begin
        cnt_r <= cnt_r + DB_W'(1'b1);
      end
    end
    assign stable_s[g] = level_r;
  end

  // Previous debounced level, for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d_r <= {NB{1'b0}};
    end else begin
      stable_d_r <= stable_s;
    end
  end

  assign press_s     = stable_s & ~stable_d_r;
  assign sel_press_s = press_s[4];

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [3:0] rpt_s;

  for (genvar g = 0; g < 4; g++) begin : g_rpt
    logic [RPT_W-1:0] cnt_r;
    logic             armed_r;
    // cnt_r equals the number of edges since the press (or last repeat) while the level stays high.
    assign rpt_s[g] = stable_s[g] &&
                      (cnt_r == (armed_r ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY)));
    // Repeat timer: cleared on release, restarted after every emitted repeat.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r   <= {RPT_W{1'b0}};
        armed_r <= 1'b0;
      end else if (!stable_s[g]) begin
        cnt_r   <= {RPT_W{1'b0}};
        armed_r <= 1'b0;
      end else if (rpt_s[g]) begin
        cnt_r   <= RPT_W'(1'b1);
        armed_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + RPT_W'(1'b1);
      end
    end
  end

  assign dir_s = press_s[3:0] | rpt_s;
`else
  assign dir_s = press_s[3:0];
`endif

  // Next cursor row/col: highest-priority direction only, clamp or wrap at the edge.
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    if (dir_s[0]) begin
      if (row_r != {LOC_W{1'b0}}) row_nxt_s = row_r - LOC_W'(1'b1);
      else if (WRAP != 0)         row_nxt_s = LAST;
      else                        row_nxt_s = row_r;
    end else if (dir_s[1]) begin
      if (row_r != LAST)          row_nxt_s = row_r + LOC_W'(1'b1);
      else if (WRAP != 0)         row_nxt_s = {LOC_W{1'b0}};
      else                        row_nxt_s = row_r;
    end else if (dir_s[2]) begin
      if (col_r != {LOC_W{1'b0}}) col_nxt_s = col_r - LOC_W'(1'b1);
      else if (WRAP != 0)         col_nxt_s = LAST;
      else                        col_nxt_s = col_r;
    end else if (dir_s[3]) begin
      if (col_r != LAST)          col_nxt_s = col_r + LOC_W'(1'b1);
      else if (WRAP != 0)         col_nxt_s = {LOC_W{1'b0}};
      else                        col_nxt_s = col_r;
    end else begin
      row_nxt_s = row_r;
      col_nxt_s = col_r;
    end
  end

  // Cursor registers; location is kept as a flat index alongside row/col.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_r      <= {LOC_W{1'b0}};
      col_r      <= {LOC_W{1'b0}};
      location_r <= {LOC_W{1'b0}};
    end else begin
      row_r      <= row_nxt_s;
      col_r      <= col_nxt_s;
      location_r <= row_nxt_s * DIM + col_nxt_s;
    end
  end

  // Select FSM; it sees location_r, i.e. the cursor before any same-cycle move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      sel_loc_r    <= {LOC_W{1'b0}};
      sel_valid_r  <= 1'b0;
      move_valid_r <= 1'b0;
      move_src_r   <= {LOC_W{1'b0}};
      move_dst_r   <= {LOC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_press_s) begin
            sel_loc_r   <= location_r;
            sel_valid_r <= 1'b1;
            state_r     <= ST_PICKED;
          end
        end
        ST_PICKED: begin
          if (sel_press_s) begin
            if (location_r == sel_loc_r) begin
              sel_valid_r <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              move_src_r   <= sel_loc_r;
              move_dst_r   <= location_r;
              move_valid_r <= 1'b1;
              state_r      <= ST_WAIT_ACK;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (req.move_ready) begin
            move_valid_r <= 1'b0;
            sel_valid_r  <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          move_valid_r <= 1'b0;
          sel_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign location       = location_r;
  assign sel_loc        = sel_loc_r;
  assign sel_valid      = sel_valid_r;
  assign req.move_valid = move_valid_r;
  assign req.move_src   = move_src_r;
  assign req.move_dst   = move_dst_r;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed and randomised bench for board_cursor_ctrl against a press-level board model.
`timescale 1ns/1ps
module tb_board_cursor_ctrl;
  localparam int BOARD_DIM = 8;
  localparam int LOC_W     = 6;
  localparam int DEB       = 4;
  localparam int WRAP_P    = 0;
  localparam int RD        = 20;
  localparam int RP        = 8;

  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LT = 5'b00100,
                         B_RT = 5'b01000, B_SEL = 5'b10000, B_NONE = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
  logic ready = 1'b0;
  logic [LOC_W-1:0] location, sel_loc;
  logic sel_valid;

  board_cursor_ctrl_if #(.LOC_W(LOC_W)) bus ();
  assign bus.move_ready = ready;

  board_cursor_ctrl #(
    .BOARD_DIM(BOARD_DIM), .LOC_W(LOC_W), .DEBOUNCE_CYCLES(DEB), .WRAP(WRAP_P),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_btn_up(up), .in_btn_down(down), .in_btn_left(left), .in_btn_right(right),
    .in_selected(sel),
    .location(location), .sel_loc(sel_loc), .sel_valid(sel_valid),
    .req(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Board model: cursor as row/col, selection as a simple stage number (0 none, 1 picked, 2 requested).
  int m_row, m_col, m_stage, m_sel, m_selv, m_mv, m_src, m_dst;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {sel, right, left, down, up} = m;
  endtask

  task automatic m_reset();
    m_row = 0; m_col = 0; m_stage = 0; m_sel = 0; m_selv = 0; m_mv = 0; m_src = 0; m_dst = 0;
  endtask

  function automatic int step(input int v, input int d);
    int n;
    n = v + d;
    if (n < 0)          return (WRAP_P != 0) ? BOARD_DIM - 1 : v;
    if (n >= BOARD_DIM) return (WRAP_P != 0) ? 0 : v;
    return n;
  endfunction

  task automatic m_ack();
    if (m_stage == 2 && ready) begin
      m_mv = 0; m_selv = 0; m_stage = 0;
    end
  endtask

  task automatic m_press(input logic [4:0] m);
    int loc;
    loc = m_row * BOARD_DIM + m_col;
    if (m[4]) begin
      if (m_stage == 0) begin
        m_sel = loc; m_selv = 1; m_stage = 1;
      end else if (m_stage == 1) begin
        if (loc == m_sel) begin
          m_selv = 0; m_stage = 0;
        end else begin
          m_src = m_sel; m_dst = loc; m_mv = 1; m_stage = 2;
        end
      end
    end
    if (m[0])      m_row = step(m_row, -1);
    else if (m[1]) m_row = step(m_row, 1);
    else if (m[2]) m_col = step(m_col, -1);
    else if (m[3]) m_col = step(m_col, 1);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".loc"}, int'(location), m_row * BOARD_DIM + m_col);
    check({tag, ".sel_valid"}, int'(sel_valid), m_selv);
    if (m_selv != 0) check({tag, ".sel_loc"}, int'(sel_loc), m_sel);
    check({tag, ".move_valid"}, int'(bus.move_valid), m_mv);
    check({tag, ".move_src"}, int'(bus.move_src), m_src);
    check({tag, ".move_dst"}, int'(bus.move_dst), m_dst);
  endtask

  task automatic press(input string tag, input logic [4:0] m);
    m_ack();
    set_btn(m);
    tick(10);
    m_press(m);
    m_ack();
    set_btn(B_NONE);
    tick(10);
    check_all(tag);
  endtask

  initial begin
    int exp_rep [5];
    m_reset();

    // Reset with random buttons.
    set_btn(5'($urandom_range(0, 31)));
    ready = 1'($urandom_range(0, 1));
    #1;
    check_all("reset");
    tick(3);
    check_all("reset_hold");
    set_btn(B_NONE);
    ready = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(20);
    check_all("idle20");

    // Bounce then hold: exactly one step, DEB+3 edges after the hold starts.
    for (int i = 0; i < 5; i++) begin
      right = 1'b1; tick(2);
      right = 1'b0; tick(2);
    end
    check("bounce_none", int'(location), 0);
    right = 1'b1;
    tick(DEB + 2);
    check("bounce_pre", int'(location), 0);
    tick(1);
    check("bounce_edge", int'(location), 1);
    m_col = 1;
    tick(10);
    check("bounce_held", int'(location), 1);
    right = 1'b0;
    tick(12);
    check("bounce_release", int'(location), 1);

    // Board edges and priority.
    for (int i = 0; i < 6; i++) press("to_col7", B_RT);
    press("right_edge", B_RT);
    check("right_edge_abs", int'(location), (WRAP_P != 0) ? 0 : 7);
    for (int i = 0; i < 4; i++) press("to_3", B_LT);
    press("top_edge", B_UP);
    check("top_edge_abs", int'(location), (WRAP_P != 0) ? 59 : 3);
    press("to_11", B_DN);
    press("to_10", B_LT);
    press("to_9", B_LT);
    press("up_left", B_UP | B_LT);
    check("up_left_abs", int'(location), 1);

    // Pick, move, request, handshake.
    press("to_9b", B_DN);
    press("pick9", B_SEL);
    press("to_17", B_DN);
    press("to_18", B_RT);
    press("request", B_SEL);
    check("req_valid", int'(bus.move_valid), 1);
    check("req_src", int'(bus.move_src), 9);
    check("req_dst", int'(bus.move_dst), 18);
    tick(10);
    press("sel_ignored", B_SEL);
    ready = 1'b1;
    tick(1);
    check("ack_mv", int'(bus.move_valid), 0);
    check("ack_selv", int'(sel_valid), 0);
    m_ack();
    ready = 1'b0;
    tick(2);
    check_all("after_ack");

    // Deselect, then reset while a request is pending.
    press("to_10c", B_UP);
    press("to_2", B_UP);
    for (int i = 0; i < 3; i++) press("to_5", B_RT);
    press("pick5", B_SEL);
    press("desel5", B_SEL);
    press("pick5b", B_SEL);
    press("to_6", B_RT);
    press("req56", B_SEL);
    check("req56_valid", int'(bus.move_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check("rst_mid_mv", int'(bus.move_valid), 0);
    check_all("rst_mid");
    tick(2);
    rst = 1'b1;
    tick(2);

    // Held down button: auto-repeat timing, or a single step without the feature.
`ifdef AUTO_REPEAT_EN
    exp_rep = '{8, 16, 24, 32, 40};
`else
    exp_rep = '{8, 8, 8, 8, 8};
`endif
    down = 1'b1;
    tick(DEB + 2);
    check("rep_pre", int'(location), 0);
    tick(1);
    check("rep_press", int'(location), exp_rep[0]);
    tick(RD - 1);
    check("rep_before_first", int'(location), exp_rep[0]);
    tick(1);
    check("rep_first", int'(location), exp_rep[1]);
    tick(RP);
    check("rep_second", int'(location), exp_rep[2]);
    tick(RP);
    check("rep_third", int'(location), exp_rep[3]);
    tick(RP);
    check("rep_fourth", int'(location), exp_rep[4]);
    down = 1'b0;
    tick(15);
    check("rep_release", int'(location), exp_rep[4]);
    m_row = exp_rep[4] / BOARD_DIM;
    m_col = 0;

    // Random presses and handshake readiness against the model.
    for (int i = 0; i < 40; i++) begin
      ready = ($urandom_range(0, 2) == 0);
      press("rand", 5'($urandom_range(1, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
